apb4_reg_slave: RTL and testbench

Parametrised APB4 completer with an on-block register bank, the successor to our plain APB3 signal bundle. Adds PSTRB byte lanes, PPROT-based write protection, a programmable wait-state generator, per-register read-only masking and PSLVERR signalling for bad accesses. Sits behind the APB fabric and exposes the register contents and per-register write pulses to the consuming logic.

---
 rtl/apb4_reg_slave_pkg.sv | 32 +++
 rtl/apb4_reg_slave_if.sv | 29 ++
 rtl/apb4_access_fsm.sv | 83 ++++++++
 rtl/apb4_reg_slave.sv | 120 ++++++++++++
 tb/tb_apb4_reg_slave.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/apb4_reg_slave_pkg.sv
// Shared types and helpers for the APB4 register slave: FSM state, PPROT bit
// positions, byte-strobe expansion and address-decode width helpers.
package apb_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam int PPROT_PRIV  = 0;
    localparam int PPROT_NSEC  = 1;
    localparam int PPROT_INSTR = 2;

    function automatic int align_bits(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    function automatic int idx_bits(input int nregs);
        return $clog2(nregs);
    endfunction

    // Expands up to four byte strobes into a 32-bit bit mask; narrower buses
    // use the low bits of the result.
    function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/apb4_reg_slave_if.sv
// APB4 bus bundle between the fabric (master) and the register slave.
// Handshake: a transfer is a setup cycle (PSEL=1, PENABLE=0) followed by access
// cycles (PSEL=1, PENABLE=1); it completes on the edge where PREADY=1, and
// PSLVERR/PRDATA are only meaningful in that cycle.
interface apb4_reg_slave_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_W-1:0]     PADDR;
    logic [DATA_W-1:0]     PWDATA;
    logic [DATA_W/8-1:0]   PSTRB;
    logic [2:0]            PPROT;
    logic [DATA_W-1:0]     PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb4_access_fsm.sv
// APB4 transfer sequencer: tracks setup/access phases, counts wait states and
// drives PREADY/PSLVERR purely from registered state.
module apb4_access_fsm
    import apb_pkg::*;
#(
    parameter int WAIT_CYCLES = 0
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   psel,
    input  logic   penable,
    input  logic   err_in,
    output state_t state,
    output logic   pready,
    output logic   pslverr,
    output logic   err,
    output logic   start,
    output logic   complete,
    output logic   abort
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       err_q, err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        start    = 1'b0;
        complete = 1'b0;
        abort    = 1'b0;
        pready   = (state_q == ACCESS) && (cnt_q == 4'd0);
        pslverr  = pready && err_q;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                    cnt_d   = WAIT_LOAD;
                    err_d   = err_in;
                    start   = 1'b1;
                end
            end
            ACCESS: begin
                if (!psel) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                    err_d   = 1'b0;
                end else if (!penable) begin
                    // A fresh setup phase restarts the sequence in place.
                    start   = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    err_d   = err_in;
                end else if (pready) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    err_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign state = state_q;
    assign err   = err_q;

endmodule

// File: rtl/apb4_reg_slave.sv
// APB4 completer with a byte-strobed register bank, PPROT write protection,
// read-only masking and PSLVERR on bad accesses.
module apb4_reg_slave
    import apb_pkg::*;
#(
    parameter int                 ADDR_W      = 32,
    parameter int                 DATA_W      = 32,
    parameter int                 NREGS       = 8,
    parameter int                 WAIT_CYCLES = 0,
    parameter logic [NREGS-1:0]   RO_MASK     = '0,
    parameter bit                 PRIV_WR     = 1'b0,
    parameter logic [DATA_W-1:0]  RESET_VAL   = '0
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    apb4_reg_slave_if.slave          apb,
    output logic [NREGS*DATA_W-1:0]  reg_q,
    output logic [NREGS-1:0]         reg_wr,
    output state_t                   fsm_state
);

    localparam int                STRB_W     = DATA_W / 8;
    localparam int                ALIGN      = align_bits(DATA_W);
    localparam int                IDX_W      = idx_bits(NREGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NREGS * STRB_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(STRB_W - 1);

    logic [DATA_W-1:0] regs [NREGS];
    logic [IDX_W-1:0]  idx_in, idx_q;
    logic              wr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [STRB_W-1:0] strb_q;
    logic              err_in, err_q;
    logic              start, complete, abort, commit;
    logic [31:0]       mask_full;
    logic [DATA_W-1:0] mask;

    assign idx_in = apb.PADDR[ALIGN +: IDX_W];

    always_comb begin
        err_in = 1'b0;
        if (apb.PADDR >= ADDR_LIMIT)                          err_in = 1'b1;
        if ((apb.PADDR & ALIGN_MASK) != '0)                   err_in = 1'b1;
        if (apb.PWRITE && RO_MASK[idx_in])                    err_in = 1'b1;
        if (apb.PWRITE && PRIV_WR && !apb.PPROT[PPROT_PRIV])  err_in = 1'b1;
        if (!apb.PWRITE && (apb.PSTRB != '0))                 err_in = 1'b1;
    end

    apb4_access_fsm #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_fsm (
        .clk      (PCLK),
        .rst_n    (PRESETn),
        .psel     (apb.PSEL),
        .penable  (apb.PENABLE),
        .err_in   (err_in),
        .state    (fsm_state),
        .pready   (apb.PREADY),
        .pslverr  (apb.PSLVERR),
        .err      (err_q),
        .start    (start),
        .complete (complete),
        .abort    (abort)
    );

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (start) begin
            idx_q   <= idx_in;
            wr_q    <= apb.PWRITE;
            wdata_q <= apb.PWDATA;
            strb_q  <= apb.PSTRB;
        end
    end

    assign mask_full = strb_to_mask(4'(strb_q));
    assign mask      = mask_full[DATA_W-1:0];
    assign commit    = complete && wr_q && !err_q;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= RESET_VAL;
            end
        end else if (commit) begin
            regs[idx_q] <= (regs[idx_q] & ~mask) | (wdata_q & mask);
        end
    end

    // The pulse lands in the cycle after the commit edge, even for PSTRB=0.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            reg_wr <= '0;
        end else begin
            reg_wr <= '0;
            if (commit) begin
                reg_wr[idx_q] <= 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            apb.PRDATA <= '0;
        end else if (start) begin
            apb.PRDATA <= (!apb.PWRITE && !err_in) ? regs[idx_in] : '0;
        end else if (complete || abort) begin
            apb.PRDATA <= '0;
        end
    end

    for (genvar g = 0; g < NREGS; g++) begin : g_regq
        assign reg_q[g*DATA_W +: DATA_W] = regs[g];
    end

endmodule

// File: tb/tb_apb4_reg_slave.sv
// Bench for apb4_reg_slave: two instances (no wait states with RO/privilege
// checks, and three wait states) driven by directed and random APB transfers.
module tb_apb4_reg_slave;
    import apb_pkg::*;

    logic PCLK = 1'b0;
    logic PRESETn;

    always #5 PCLK = ~PCLK;

    apb4_reg_slave_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    apb4_reg_slave_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    logic [255:0] reg_q0, reg_q1;
    logic [7:0]   reg_wr0, reg_wr1;
    state_t       st0, st1;

    apb4_reg_slave #(
        .ADDR_W(32), .DATA_W(32), .NREGS(8), .WAIT_CYCLES(0),
        .RO_MASK(8'h01), .PRIV_WR(1'b1), .RESET_VAL(32'h0000_0000)
    ) dut0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus0),
        .reg_q(reg_q0), .reg_wr(reg_wr0), .fsm_state(st0)
    );

    apb4_reg_slave #(
        .ADDR_W(32), .DATA_W(32), .NREGS(8), .WAIT_CYCLES(3),
        .RO_MASK(8'h80), .PRIV_WR(1'b0), .RESET_VAL(32'h0000_5A5A)
    ) dut1 (
        .PCLK(PCLK), .PRESETn(PRESETn), .apb(bus1),
        .reg_q(reg_q1), .reg_wr(reg_wr1), .fsm_state(st1)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          wait_of [2] = '{0, 3};
    logic [7:0]  ro_of   [2] = '{8'h01, 8'h80};
    bit          priv_of [2] = '{1'b1, 1'b0};
    logic [31:0] rst_of  [2] = '{32'h0000_0000, 32'h0000_5A5A};
    logic [31:0] model   [2][8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input bit sel, input bit en, input bit wr,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb, input logic [2:0] prot);
        if (d == 0) begin
            bus0.PSEL = sel; bus0.PENABLE = en; bus0.PWRITE = wr; bus0.PADDR = addr;
            bus0.PWDATA = data; bus0.PSTRB = strb; bus0.PPROT = prot;
        end else begin
            bus1.PSEL = sel; bus1.PENABLE = en; bus1.PWRITE = wr; bus1.PADDR = addr;
            bus1.PWDATA = data; bus1.PSTRB = strb; bus1.PPROT = prot;
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? bus0.PREADY : bus1.PREADY;
    endfunction

    function automatic logic serr(input int d);
        return (d == 0) ? bus0.PSLVERR : bus1.PSLVERR;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? bus0.PRDATA : bus1.PRDATA;
    endfunction

    function automatic logic [31:0] regq(input int d, input int i);
        return (d == 0) ? reg_q0[i*32 +: 32] : reg_q1[i*32 +: 32];
    endfunction

    function automatic logic [7:0] rwr(input int d);
        return (d == 0) ? reg_wr0 : reg_wr1;
    endfunction

    function automatic logic [31:0] fsm_of(input int d);
        return (d == 0) ? 32'(st0) : 32'(st1);
    endfunction

    // Reference model: rules for a bad access and the byte-merge of a write.
    function automatic bit exp_err(input int d, input bit wr, input logic [31:0] addr,
                                   input logic [3:0] strb, input logic [2:0] prot);
        int idx;
        idx = int'((addr / 4) % 8);
        if (addr >= 32)                     return 1'b1;
        if (addr % 4 != 0)                  return 1'b1;
        if (wr && ro_of[d][idx])            return 1'b1;
        if (wr && priv_of[d] && !prot[0])   return 1'b1;
        if (!wr && strb != 4'd0)            return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[b*8 +: 8] = data[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic reset_models();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) model[d][i] = rst_of[d];
    endtask

    task automatic check_regs(input int d);
        for (int i = 0; i < 8; i++)
            chk($sformatf("dut%0d reg_q[%0d]", d, i), regq(d, i), model[d][i]);
    endtask

    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot);
        bit          e;
        int          idx;
        int          waits;
        logic [31:0] exp_rd;
        logic [7:0]  exp_wr;
        e      = exp_err(d, wr, addr, strb, prot);
        idx    = int'((addr / 4) % 8);
        exp_rd = (!wr && !e) ? model[d][idx] : 32'h0;
        exp_wr = (wr && !e) ? 8'(1 << idx) : 8'h00;
        @(negedge PCLK);
        drive(d, 1'b1, 1'b0, wr, addr, data, strb, prot);
        @(negedge PCLK);
        drive(d, 1'b1, 1'b1, wr, addr, data, strb, prot);
        waits = 0;
        while (!rdy(d) && waits < 40) begin
            @(negedge PCLK);
            waits++;
        end
        chk($sformatf("dut%0d wait_states a=%0h", d, addr), 32'(waits), 32'(wait_of[d]));
        chk($sformatf("dut%0d pslverr a=%0h", d, addr), 32'(serr(d)), 32'(e));
        if (!wr) chk($sformatf("dut%0d prdata a=%0h", d, addr), rdat(d), exp_rd);
        if (wr && !e) model[d][idx] = merge(model[d][idx], data, strb);
        @(negedge PCLK);
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        chk($sformatf("dut%0d reg_wr pulse", d), 32'(rwr(d)), 32'(exp_wr));
        chk($sformatf("dut%0d pready after", d), 32'(rdy(d)), 32'h0);
        chk($sformatf("dut%0d prdata cleared", d), rdat(d), 32'h0);
        check_regs(d);
        @(negedge PCLK);
        chk($sformatf("dut%0d reg_wr cleared", d), 32'(rwr(d)), 32'h0);
    endtask

    initial begin
        logic [31:0] a;
        bit          w;
        logic [3:0]  s;
        int          d;

        PRESETn = 1'b0;
        drive(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        reset_models();
        repeat (3) @(negedge PCLK);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst dut%0d pready", k), 32'(rdy(k)), 32'h0);
            chk($sformatf("rst dut%0d pslverr", k), 32'(serr(k)), 32'h0);
            chk($sformatf("rst dut%0d prdata", k), rdat(k), 32'h0);
            chk($sformatf("rst dut%0d reg_wr", k), 32'(rwr(k)), 32'h0);
            chk($sformatf("rst dut%0d state", k), fsm_of(k), 32'(IDLE));
            check_regs(k);
        end
        PRESETn = 1'b1;

        // Basic write/read, then strobed merge on register 2.
        xfer(0, 1'b1, 32'h4, 32'hDEADBEEF, 4'hF, 3'b001);
        xfer(0, 1'b0, 32'h4, 32'h0, 4'h0, 3'b001);
        xfer(0, 1'b1, 32'h8, 32'h11223344, 4'hF, 3'b001);
        xfer(0, 1'b1, 32'h8, 32'hAABBCCDD, 4'b0101, 3'b001);
        xfer(0, 1'b0, 32'h8, 32'h0, 4'h0, 3'b000);
        chk("strobe merge reg2", regq(0, 2), 32'h11BB33DD);

        // Error accesses: read-only, unprivileged, out of range, misaligned.
        xfer(0, 1'b1, 32'h0,  32'hFFFFFFFF, 4'hF, 3'b001);
        xfer(0, 1'b1, 32'h4,  32'h12345678, 4'hF, 3'b000);
        xfer(0, 1'b0, 32'h20, 32'h0, 4'h0, 3'b001);
        xfer(0, 1'b0, 32'h2,  32'h0, 4'h0, 3'b001);
        xfer(0, 1'b1, 32'hC,  32'h0BADF00D, 4'h0, 3'b001);

        // Wait states on the second instance.
        xfer(1, 1'b0, 32'h0, 32'h0, 4'h0, 3'b000);
        xfer(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, 3'b000);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'h0, 3'b000);

        for (int n = 0; n < 60; n++) begin
            d = n % 2;
            w = 1'(($urandom_range(0, 1)));
            a = 32'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 7) == 0) a = a + 32'($urandom_range(1, 3));
            s = w ? 4'($urandom_range(0, 15)) :
                    (($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'h0);
            xfer(d, w, a, $urandom, s, 3'($urandom_range(0, 7)));
        end

        // Abort: PSEL drops in the second wait cycle of a write.
        @(negedge PCLK);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h14, 32'h99887766, 4'hF, 3'b000);
        @(negedge PCLK);
        drive(1, 1'b1, 1'b1, 1'b1, 32'h14, 32'h99887766, 4'hF, 3'b000);
        @(negedge PCLK);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        @(negedge PCLK);
        chk("abort state", fsm_of(1), 32'(IDLE));
        chk("abort reg_wr", 32'(rwr(1)), 32'h0);
        check_regs(1);
        @(negedge PCLK);
        chk("abort reg_wr later", 32'(rwr(1)), 32'h0);
        check_regs(1);

        // Reset in the middle of an access phase.
        xfer(1, 1'b1, 32'hC, 32'h12345678, 4'hF, 3'b000);
        @(negedge PCLK);
        drive(1, 1'b1, 1'b0, 1'b1, 32'hC, 32'hFFFF0000, 4'hF, 3'b000);
        @(negedge PCLK);
        drive(1, 1'b1, 1'b1, 1'b1, 32'hC, 32'hFFFF0000, 4'hF, 3'b000);
        @(negedge PCLK);
        PRESETn = 1'b0;
        #1;
        reset_models();
        chk("midrst pready", 32'(rdy(1)), 32'h0);
        chk("midrst pslverr", 32'(serr(1)), 32'h0);
        chk("midrst state", fsm_of(1), 32'(IDLE));
        check_regs(1);
        check_regs(0);
        drive(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 3'h0);
        @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(1, 1'b0, 32'hC, 32'h0, 4'h0, 3'b000);

        repeat (2) @(negedge PCLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
